axi_r_router: RTL and testbench
===============================

AXI_R_ROUTER -- requirements
Module: axi_r_router

Interface
REQ-001 Parameter NUM_S, default 5, number of slave read-data ports (2..16).
REQ-002 Parameter NUM_M, default 2, number of master read-data ports (1..8).
REQ-003 Parameter ID_BITS, default 4, master-side RID width.
REQ-004 Parameter DATA_BITS, default 32, RDATA width.
REQ-005 Derived MB = max(1, clog2(NUM_M)); slave-side RID width IDS_BITS = ID_BITS+MB; upper MB bits = destination master index.
REQ-006 ACLK  in  1  clock; single clock domain, all state on rising edge.
REQ-007 ARESETn  in  1  asynchronous active-low reset.
REQ-008 RID_S  in  NUM_S*IDS_BITS  slave RIDs, slave i at slice i.
REQ-009 RDATA_S  in  NUM_S*DATA_BITS  slave RDATA.
REQ-010 RRESP_S  in  NUM_S*2  slave RRESP.
REQ-011 RLAST_S / RVALID_S  in  NUM_S each  slave RLAST / RVALID.
REQ-012 RREADY_S  out  NUM_S  per-slave RREADY.
REQ-013 RREADY_M  in  NUM_M  per-master RREADY.
REQ-014 RID_M / RDATA_M / RRESP_M  out  ID_BITS / DATA_BITS / 2  shared to all masters (lower ID bits of granted slave).
REQ-015 RLAST_M  out  1  shared; RVALID_M  out  NUM_M  per-master valid.
REQ-016 GNT_IDX  out  clog2(NUM_S)  current grant index (debug); GNT_LOCK  out  1  burst-lock flag.

Function
REQ-017 FSM states IDLE, BURST; reset state IDLE, round-robin pointer PTR = 0, held grant HG = 0.
REQ-018 IDLE: grant G = first i with RVALID_S[i]=1 searching PTR, PTR+1, ..., wrapping modulo NUM_S; no valid slave -> no grant, all RVALID_M=0, all RREADY_S=0.
REQ-019 BURST: G = HG regardless of other RVALID_S.
REQ-020 Forwarding is combinational, zero latency: RID_M = RID_S[G][ID_BITS-1:0], RDATA/RRESP/RLAST from slave G; no grant -> data outputs 0.
REQ-021 Destination D = RID_S[G][IDS_BITS-1:ID_BITS]; RVALID_M[D] = RVALID_S[G], other RVALID_M = 0.
REQ-022 READY = RREADY_M[D] if D < NUM_M, else 1 (unmapped beats drained and discarded, no master sees valid).
REQ-023 RREADY_S[G] = READY & RVALID_S[G]; all other RREADY_S = 0.
REQ-024 Handshake HS = RVALID_S[G] & READY.
REQ-025 IDLE -> BURST when grant exists and not (HS & RLAST_S[G]); HG <= G (holds grant across stalled first beat and multi-beat bursts).
REQ-026 IDLE with HS & RLAST_S[G] (single-beat): stay IDLE, PTR <= (G+1) mod NUM_S.
REQ-027 BURST -> IDLE on HS & RLAST_S[HG]; PTR <= (HG+1) mod NUM_S; otherwise hold.
REQ-028 PTR and HG change only on transitions above; no grant switch while GNT_LOCK=1.
REQ-029 GNT_LOCK = 1 in BURST, 0 in IDLE; GNT_IDX = G (HG in BURST, 0 when no grant).
REQ-030 Back-to-back bursts: new grant allowed in cycle following last-beat HS, no bubble beyond that one cycle's arbitration.
REQ-031 RVALID_S of granted slave dropping mid-burst (protocol violation) keeps BURST; outputs follow slave, no master valid.

Reset
REQ-032 ARESETn low asynchronously forces IDLE, PTR=0, HG=0, GNT_LOCK=0; outputs then follow REQ-018..020 combinationally.
REQ-033 Reset mid-burst discards lock; after release arbitration restarts from slave 0.

Verification
REQ-034 Single-beat: S1 RVALID, RID=0x13, RLAST=1, M1 ready -> RVALID_M=2'b10, RID_M=0x3, RREADY_S[1]=1 same cycle, PTR becomes 2, GNT_LOCK stays 0.
REQ-035 Burst lock: S0 4-beat burst to M0, S2 valid from cycle 2 -> S2 not granted until cycle after S0 beat 4 HS; GNT_IDX=0 for 4 cycles.
REQ-036 Round-robin fairness: S0, S3 continuously issue single beats, PTR starts 0 -> grants alternate 0,3,0,3.
REQ-037 Backpressure: M0 RREADY=0 for 3 cycles on first beat of S4 -> GNT_LOCK=1, RDATA_M stable, RREADY_S=0 until M0 ready.
REQ-038 Unmapped destination (NUM_M=3, ID top bits=3) -> all RVALID_M=0, RREADY_S[G]=1, beat consumed.
REQ-039 Reset mid-burst at beat 2 of S2 -> GNT_LOCK=0, PTR=0 immediately; after release pending S0 and S2 valid -> S0 granted first.

Source files
------------

// File: rtl/axi_r_router_if.sv
// Read-data channel bundle for the R router: slave-side beats in, shared master-side beat out.
// The router attaches through the slave modport; the surrounding fabric uses the master modport.
interface axi_r_router_if #(
    parameter int unsigned NUM_S     = 5,
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned DATA_BITS = 32
);
    localparam int unsigned MB       = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned IDS_BITS = ID_BITS + MB;

    logic [NUM_S*IDS_BITS-1:0]  RID_S;
    logic [NUM_S*DATA_BITS-1:0] RDATA_S;
    logic [NUM_S*2-1:0]         RRESP_S;
    logic [NUM_S-1:0]           RLAST_S;
    logic [NUM_S-1:0]           RVALID_S;
    logic [NUM_S-1:0]           RREADY_S;

    logic [NUM_M-1:0]           RREADY_M;
    logic [ID_BITS-1:0]         RID_M;
    logic [DATA_BITS-1:0]       RDATA_M;
    logic [1:0]                 RRESP_M;
    logic                       RLAST_M;
    logic [NUM_M-1:0]           RVALID_M;

    modport slave (
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
        output RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );

    modport master (
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
        input  RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );
endinterface

// File: rtl/axi_r_router.sv
// Routes read-data beats from NUM_S slaves to NUM_M masters by the RID destination bits.
// Round-robin arbitration per burst; the grant is locked until the last beat handshakes.
module axi_r_router #(
    parameter int unsigned NUM_S     = 5,
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi_r_router_if.slave            bus,
    output logic [$clog2(NUM_S)-1:0] GNT_IDX,
    output logic                     GNT_LOCK
);
    localparam int unsigned MB       = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned IDS_BITS = ID_BITS + MB;
    localparam int unsigned SB       = $clog2(NUM_S);
    localparam int unsigned SW       = SB + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_n;
    logic [SB-1:0]       ptr, ptr_n;
    logic [SB-1:0]       hg, hg_n;

    logic                grant;
    logic [SB-1:0]       g;
    logic [SW-1:0]       idx;
    logic [SB-1:0]       idx_s;
    logic [IDS_BITS-1:0] rid_g;
    logic [DATA_BITS-1:0] data_g;
    logic [1:0]          resp_g;
    logic                last_g;
    logic                vld_g;
    logic [MB-1:0]       dst;
    logic                ready;
    logic                hs;

    function automatic logic [SB-1:0] wrap_inc(input logic [SB-1:0] x);
        return (32'(x) == NUM_S - 1) ? '0 : x + SB'(1);
    endfunction

    // Grant selection: held grant in BURST, otherwise first valid slave from PTR onward
    always_comb begin
        grant = 1'b0;
        g     = '0;
        idx   = '0;
        idx_s = '0;
        if (state == BURST) begin
            grant = 1'b1;
            g     = hg;
        end else begin
            for (int unsigned k = 0; k < NUM_S; k++) begin
                idx = {1'b0, ptr} + SW'(k);
                if (idx >= SW'(NUM_S)) idx = idx - SW'(NUM_S);
                idx_s = SB'(idx);
                if (!grant && bus.RVALID_S[idx_s]) begin
                    grant = 1'b1;
                    g     = idx_s;
                end
            end
        end
    end

    // Zero-latency forwarding of the granted slave's beat
    always_comb begin
        rid_g  = '0;
        data_g = '0;
        resp_g = '0;
        last_g = 1'b0;
        vld_g  = 1'b0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            if (grant && g == SB'(i)) begin
                rid_g  = bus.RID_S[i*IDS_BITS +: IDS_BITS];
                data_g = bus.RDATA_S[i*DATA_BITS +: DATA_BITS];
                resp_g = bus.RRESP_S[i*2 +: 2];
                last_g = bus.RLAST_S[i];
                vld_g  = bus.RVALID_S[i];
            end
        end
    end

    assign dst = rid_g[IDS_BITS-1:ID_BITS];

    // Destination decode; an unmapped destination is always ready so its beats drain
    always_comb begin
        ready        = 1'b1;
        bus.RVALID_M = '0;
        for (int unsigned j = 0; j < NUM_M; j++) begin
            if (dst == MB'(j)) begin
                ready           = bus.RREADY_M[j];
                bus.RVALID_M[j] = vld_g;
            end
        end
    end

    assign hs = vld_g & ready;

    always_comb begin
        bus.RREADY_S = '0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            bus.RREADY_S[i] = hs && (g == SB'(i));
        end
    end

    assign bus.RID_M   = rid_g[ID_BITS-1:0];
    assign bus.RDATA_M = data_g;
    assign bus.RRESP_M = resp_g;
    assign bus.RLAST_M = last_g;
    assign GNT_IDX     = g;
    assign GNT_LOCK    = (state == BURST);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            ptr   <= '0;
            hg    <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hg    <= hg_n;
        end
    end

    // A stalled first beat also locks, so the grant cannot move under a waiting beat
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hg_n    = hg;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (hs && last_g) begin
                        ptr_n = wrap_inc(g);
                    end else begin
                        state_n = BURST;
                        hg_n    = g;
                    end
                end
            end
            BURST: begin
                if (hs && last_g) begin
                    state_n = IDLE;
                    ptr_n   = wrap_inc(hg);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_r_router.sv
// Self-checking bench for axi_r_router (5 slaves, 3 masters so destination 3 is unmapped).
// Expected beats go into a scoreboard queue as stimulus is driven and are popped at each handshake.
module tb_axi_r_router;
    localparam int unsigned NS = 5;
    localparam int unsigned NM = 3;
    localparam int unsigned IB = 4;
    localparam int unsigned DB = 32;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [2:0] gnt_idx;
    logic       gnt_lock;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [2:0]  slv;
        logic [3:0]  rid;
        logic [31:0] data;
        logic        last;
        logic [2:0]  vm;
    } exp_t;

    exp_t exp_q[$];

    axi_r_router_if #(.NUM_S(NS), .NUM_M(NM), .ID_BITS(IB), .DATA_BITS(DB)) bus ();

    axi_r_router #(.NUM_S(NS), .NUM_M(NM), .ID_BITS(IB), .DATA_BITS(DB)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .bus      (bus),
        .GNT_IDX  (gnt_idx),
        .GNT_LOCK (gnt_lock)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_slv(input int s, input logic v, input logic [5:0] rid,
                           input logic [31:0] d, input logic l);
        bus.RVALID_S[s]         = v;
        bus.RID_S[s*6 +: 6]     = rid;
        bus.RDATA_S[s*32 +: 32] = d;
        bus.RRESP_S[s*2 +: 2]   = d[1:0];
        bus.RLAST_S[s]          = l;
    endtask

    task automatic clear_all();
        bus.RVALID_S = '0;
        bus.RID_S    = '0;
        bus.RDATA_S  = '0;
        bus.RRESP_S  = '0;
        bus.RLAST_S  = '0;
    endtask

    function automatic logic [11:0] obs();
        return {gnt_lock, gnt_idx, bus.RVALID_M, bus.RREADY_S};
    endfunction

    function automatic exp_t mk(input logic [2:0] s, input logic [3:0] r, input logic [31:0] d,
                                input logic l, input logic [2:0] vm);
        exp_t e;
        e.slv = s; e.rid = r; e.data = d; e.last = l; e.vm = vm;
        return e;
    endfunction

    task automatic test_reset();
        ARESETn      = 1'b0;
        bus.RREADY_M = '0;
        clear_all();
        #1;
        n_chk++;
        if (obs() !== 12'h000) $display("FAIL reset_obs got %h exp %h", obs(), 12'h000);
        else n_pass++;
        n_chk++;
        if ({bus.RID_M, bus.RDATA_M, bus.RLAST_M} !== 37'd0)
            $display("FAIL reset_data got %h exp 0", {bus.RID_M, bus.RDATA_M, bus.RLAST_M});
        else n_pass++;
        step();
        step();
        ARESETn = 1'b1;
        #1;
        n_chk++;
        if (obs() !== 12'h000) $display("FAIL reset_release_obs got %h exp %h", obs(), 12'h000);
        else n_pass++;
    endtask

    task automatic test_single_beat();
        exp_t e;
        bus.RREADY_M = '1;
        set_slv(1, 1'b1, 6'h13, 32'h0000_00A1, 1'b1);
        exp_q.push_back(mk(3'd1, 4'h3, 32'h0000_00A1, 1'b1, 3'b010));
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd1, 3'b010, 5'b00010})
            $display("FAIL single_obs got %h exp %h", obs(), {1'b0, 3'd1, 3'b010, 5'b00010});
        else n_pass++;
        if (bus.RREADY_S != '0) begin
            n_chk++;
            e = exp_q.pop_front();
            if ({gnt_idx, bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RVALID_M} !==
                {e.slv, e.rid, e.data, e.data[1:0], e.last, e.vm})
                $display("FAIL single_beat got %h/%h exp %h/%h", bus.RID_M, bus.RDATA_M, e.rid, e.data);
            else n_pass++;
        end
        step();
        clear_all();
        // pointer now 2: with S0..S2 valid, S2 wins
        set_slv(0, 1'b1, 6'h00, 32'h0000_00B0, 1'b1);
        set_slv(1, 1'b1, 6'h01, 32'h0000_00B1, 1'b1);
        set_slv(2, 1'b1, 6'h02, 32'h0000_00B2, 1'b1);
        exp_q.push_back(mk(3'd2, 4'h2, 32'h0000_00B2, 1'b1, 3'b001));
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd2, 3'b001, 5'b00100})
            $display("FAIL single_ptr_obs got %h exp %h", obs(), {1'b0, 3'd2, 3'b001, 5'b00100});
        else n_pass++;
        if (bus.RREADY_S != '0) begin
            n_chk++;
            e = exp_q.pop_front();
            if ({gnt_idx, bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RVALID_M} !==
                {e.slv, e.rid, e.data, e.data[1:0], e.last, e.vm})
                $display("FAIL single_ptr_beat got %h/%h exp %h/%h", bus.RID_M, bus.RDATA_M, e.rid, e.data);
            else n_pass++;
        end
        step();
        clear_all();
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL single_sb_left got %0d exp 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_burst_lock();
        exp_t e;
        logic lk;
        bus.RREADY_M = '1;
        for (int k = 0; k < 4; k++) begin
            set_slv(0, 1'b1, 6'h07, 32'h100 + 32'(k), (k == 3));
            if (k >= 2) set_slv(2, 1'b1, 6'h12, 32'h0000_0200, 1'b1);
            exp_q.push_back(mk(3'd0, 4'h7, 32'h100 + 32'(k), (k == 3), 3'b001));
            lk = (k > 0);
            #1;
            n_chk++;
            if (obs() !== {lk, 3'd0, 3'b001, 5'b00001})
                $display("FAIL burst_obs_%0d got %h exp %h", k, obs(), {lk, 3'd0, 3'b001, 5'b00001});
            else n_pass++;
            if (bus.RREADY_S != '0) begin
                n_chk++;
                e = exp_q.pop_front();
                if ({gnt_idx, bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RVALID_M} !==
                    {e.slv, e.rid, e.data, e.data[1:0], e.last, e.vm})
                    $display("FAIL burst_beat_%0d got %h/%h exp %h/%h", k, bus.RID_M, bus.RDATA_M, e.rid, e.data);
                else n_pass++;
            end
            step();
        end
        set_slv(0, 1'b0, 6'h00, 32'h0, 1'b0);
        exp_q.push_back(mk(3'd2, 4'h2, 32'h0000_0200, 1'b1, 3'b010));
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd2, 3'b010, 5'b00100})
            $display("FAIL b2b_obs got %h exp %h", obs(), {1'b0, 3'd2, 3'b010, 5'b00100});
        else n_pass++;
        if (bus.RREADY_S != '0) begin
            n_chk++;
            e = exp_q.pop_front();
            if ({gnt_idx, bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RVALID_M} !==
                {e.slv, e.rid, e.data, e.data[1:0], e.last, e.vm})
                $display("FAIL b2b_beat got %h/%h exp %h/%h", bus.RID_M, bus.RDATA_M, e.rid, e.data);
            else n_pass++;
        end
        step();
        clear_all();
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL burst_sb_left got %0d exp 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [2:0] s;
        ARESETn = 1'b0;
        step();
        ARESETn = 1'b1;
        bus.RREADY_M = '1;
        set_slv(0, 1'b1, 6'h01, 32'h0000_00C0, 1'b1);
        set_slv(3, 1'b1, 6'h05, 32'h0000_00C3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            s = (c % 2 == 0) ? 3'd0 : 3'd3;
            if (s == 3'd0) exp_q.push_back(mk(3'd0, 4'h1, 32'h0000_00C0, 1'b1, 3'b001));
            else           exp_q.push_back(mk(3'd3, 4'h5, 32'h0000_00C3, 1'b1, 3'b001));
            #1;
            n_chk++;
            if (obs() !== {1'b0, s, 3'b001, 5'(1 << s)})
                $display("FAIL rr_obs_%0d got %h exp %h", c, obs(), {1'b0, s, 3'b001, 5'(1 << s)});
            else n_pass++;
            if (bus.RREADY_S != '0) begin
                n_chk++;
                e = exp_q.pop_front();
                if ({gnt_idx, bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RVALID_M} !==
                    {e.slv, e.rid, e.data, e.data[1:0], e.last, e.vm})
                    $display("FAIL rr_beat_%0d got slv %0d exp %0d", c, gnt_idx, e.slv);
                else n_pass++;
            end
            step();
        end
        clear_all();
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL rr_sb_left got %0d exp 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic lk;
        bus.RREADY_M = 3'b110;
        set_slv(4, 1'b1, 6'h09, 32'h0000_00D0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            lk = (c > 0);
            #1;
            n_chk++;
            if (obs() !== {lk, 3'd4, 3'b001, 5'b00000})
                $display("FAIL bp_obs_%0d got %h exp %h", c, obs(), {lk, 3'd4, 3'b001, 5'b00000});
            else n_pass++;
            n_chk++;
            if (bus.RDATA_M !== 32'h0000_00D0)
                $display("FAIL bp_data_%0d got %h exp %h", c, bus.RDATA_M, 32'h0000_00D0);
            else n_pass++;
            step();
        end
        bus.RREADY_M = 3'b111;
        for (int b = 0; b < 2; b++) begin
            set_slv(4, 1'b1, 6'h09, 32'h0000_00D0 + 32'(b), (b == 1));
            exp_q.push_back(mk(3'd4, 4'h9, 32'h0000_00D0 + 32'(b), (b == 1), 3'b001));
            #1;
            n_chk++;
            if (obs() !== {1'b1, 3'd4, 3'b001, 5'b10000})
                $display("FAIL bp_rel_obs_%0d got %h exp %h", b, obs(), {1'b1, 3'd4, 3'b001, 5'b10000});
            else n_pass++;
            if (bus.RREADY_S != '0) begin
                n_chk++;
                e = exp_q.pop_front();
                if ({gnt_idx, bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RVALID_M} !==
                    {e.slv, e.rid, e.data, e.data[1:0], e.last, e.vm})
                    $display("FAIL bp_beat_%0d got %h/%h exp %h/%h", b, bus.RID_M, bus.RDATA_M, e.rid, e.data);
                else n_pass++;
            end
            step();
        end
        clear_all();
        #1;
        n_chk++;
        if (obs() !== 12'h000) $display("FAIL bp_idle_obs got %h exp %h", obs(), 12'h000);
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL bp_sb_left got %0d exp 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_unmapped();
        bus.RREADY_M = '0;
        set_slv(1, 1'b1, 6'h35, 32'h0000_00E0, 1'b1);
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd1, 3'b000, 5'b00010})
            $display("FAIL unmapped_obs got %h exp %h", obs(), {1'b0, 3'd1, 3'b000, 5'b00010});
        else n_pass++;
        n_chk++;
        if (bus.RID_M !== 4'h5) $display("FAIL unmapped_rid got %h exp %h", bus.RID_M, 4'h5);
        else n_pass++;
        step();
        clear_all();
        #1;
        n_chk++;
        if (obs() !== 12'h000) $display("FAIL unmapped_after got %h exp %h", obs(), 12'h000);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bus.RREADY_M = '1;
        set_slv(2, 1'b1, 6'h02, 32'h0000_00F0, 1'b0);
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd2, 3'b001, 5'b00100})
            $display("FAIL rmb_beat0 got %h exp %h", obs(), {1'b0, 3'd2, 3'b001, 5'b00100});
        else n_pass++;
        step();
        set_slv(2, 1'b1, 6'h02, 32'h0000_00F1, 1'b0);
        #1;
        n_chk++;
        if (obs() !== {1'b1, 3'd2, 3'b001, 5'b00100})
            $display("FAIL rmb_beat1 got %h exp %h", obs(), {1'b1, 3'd2, 3'b001, 5'b00100});
        else n_pass++;
        #1;
        ARESETn = 1'b0;
        set_slv(0, 1'b1, 6'h04, 32'h0000_00F8, 1'b1);
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd0, 3'b001, 5'b00001})
            $display("FAIL rmb_in_reset got %h exp %h", obs(), {1'b0, 3'd0, 3'b001, 5'b00001});
        else n_pass++;
        step();
        ARESETn = 1'b1;
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd0, 3'b001, 5'b00001} || bus.RDATA_M !== 32'h0000_00F8)
            $display("FAIL rmb_release got %h/%h exp %h/%h", obs(), bus.RDATA_M,
                     {1'b0, 3'd0, 3'b001, 5'b00001}, 32'h0000_00F8);
        else n_pass++;
        step();
        set_slv(0, 1'b0, 6'h00, 32'h0, 1'b0);
        set_slv(2, 1'b1, 6'h02, 32'h0000_00F2, 1'b1);
        #1;
        n_chk++;
        if (obs() !== {1'b0, 3'd2, 3'b001, 5'b00100})
            $display("FAIL rmb_s2_after got %h exp %h", obs(), {1'b0, 3'd2, 3'b001, 5'b00100});
        else n_pass++;
        step();
        clear_all();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst_lock();
        test_round_robin();
        test_backpressure();
        test_unmapped();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
